// File: rtl/ins_cache_if.sv
// Bus bundle between the CPU fetch stage, the instruction cache and the
// 128-bit-block instruction memory. The cache sits on the slave side.
interface ins_cache_if;
    logic         READ;
    logic [31:0]  ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    logic [15:0]  MISS_COUNT;

    modport slave (
        input  READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, MISS_COUNT
    );

    modport master (
        output READ, ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, MISS_COUNT
    );
endinterface

// File: rtl/ins_cache.sv
// Direct-mapped, read-only instruction cache. Hits return the selected
// word combinationally; misses stall the CPU, fetch the 16-byte block from
// memory, fill the line and then serve the now-hitting PC.
module ins_cache #(
    parameter int NUM_BLOCKS = 8,
    parameter int TAG_W      = 25
) (
    input logic       CLOCK,
    input logic       RESET,
    ins_cache_if.slave bus
);
    localparam int IDX = $clog2(NUM_BLOCKS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MEM_FETCH = 2'd1,
        UPDATE    = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Line storage: valid bits are control state, tag/data are plain storage.
    logic [NUM_BLOCKS-1:0] valid_q;
    logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
    logic [127:0]          data_q [NUM_BLOCKS];

    // Miss bookkeeping: the block address is latched so a wandering PC
    // during the stall cannot redirect the fill.
    logic [27:0]  miss_blk_q;
    logic [15:0]  miss_cnt_q;
    logic [127:0] fill_q;
    logic [31:0]  inst_q;

    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] tag;
    logic [1:0]       word_sel;
    logic [31:0]      word;
    logic             hit;
    logic [IDX-1:0]   miss_idx;
    logic [TAG_W-1:0] miss_tag;
    logic             busy;
    logic [31:0]      inst_out;
    logic             unused;

    assign idx      = bus.ADDRESS[3+IDX:4];
    assign tag      = bus.ADDRESS[31:4+IDX];
    assign word_sel = bus.ADDRESS[3:2];
    assign word     = data_q[idx][32*word_sel +: 32];
    assign hit      = bus.READ & valid_q[idx] & (tag_q[idx] == tag);
    assign miss_idx = miss_blk_q[IDX-1:0];
    assign miss_tag = miss_blk_q[27:IDX];
    assign unused   = &{1'b0, bus.ADDRESS[1:0]};

    // State register; reset drops any in-flight miss immediately.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state plus CPU-facing outputs; reset forces the stall and
    // instruction outputs low while it is held.
    always_comb begin
        state_d  = state_q;
        busy     = 1'b1;
        inst_out = inst_q;
        case (state_q)
            IDLE: begin
                busy = bus.READ & ~hit;
                if (hit) inst_out = word;
                if (bus.READ && !hit) state_d = MEM_FETCH;
            end
            MEM_FETCH: begin
                if (!bus.MEM_BUSYWAIT) state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (!RESET) begin
            busy     = 1'b0;
            inst_out = 32'h0;
        end
    end

    assign bus.BUSYWAIT    = busy;
    assign bus.INSTRUCTION = inst_out;
    assign bus.MEM_READ    = (state_q == MEM_FETCH);
    assign bus.MEM_ADDRESS = miss_blk_q;
    assign bus.MISS_COUNT  = miss_cnt_q;

    // Control state: latch the missing block, count misses (saturating),
    // and mark the line valid once the fill is written.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            valid_q    <= '0;
            miss_blk_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && bus.READ && !hit) begin
                miss_blk_q <= bus.ADDRESS[31:4];
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (state_q == UPDATE) valid_q[miss_idx] <= 1'b1;
        end
    end

    // Data path: capture the memory block, write the line, and keep the
    // last hit instruction for cycles without a hit.
    always_ff @(posedge CLOCK) begin
        if (state_q == MEM_FETCH && !bus.MEM_BUSYWAIT) fill_q <= bus.MEM_READDATA;
        if (state_q == UPDATE) begin
            tag_q[miss_idx]  <= miss_tag;
            data_q[miss_idx] <= fill_q;
        end
        if (state_q == IDLE && hit) inst_q <= word;
    end
endmodule

// File: tb/tb_ins_cache.sv
// Scoreboard bench for ins_cache: stimulus pushes the expected instruction
// and miss count, a negedge monitor pops whenever the cache delivers.
module tb_ins_cache;
    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLOCK = ~CLOCK;

    ins_cache_if bus ();

    ins_cache #(.NUM_BLOCKS(8), .TAG_W(25)) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Instruction memory contents: block 0 is fixed, others are derived
    // from the block address so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [27:0] blk, input logic [1:0] w);
        logic [127:0] b0;
        b0 = 128'h00000013_00100093_00200113_00300193;
        if (blk == 28'h0) return b0[32*w +: 32];
        return {blk[21:0], 8'h5A, w};
    endfunction

    function automatic logic [127:0] mem_block(input logic [27:0] blk);
        logic [127:0] b;
        for (int w = 0; w < 4; w++) b[32*w +: 32] = mem_word(blk, w[1:0]);
        return b;
    endfunction

    // Memory responder: busy for 'lat' edges after MEM_READ rises.
    int lat = 5;
    int mem_cnt = 0;
    bit mem_active = 0;
    initial begin
        bus.MEM_BUSYWAIT = 1'b0;
        bus.MEM_READDATA = '0;
    end
    always @(negedge CLOCK) begin
        if (!RESET || !bus.MEM_READ) begin
            mem_active = 0;
            bus.MEM_BUSYWAIT = 1'b0;
        end else if (!mem_active) begin
            mem_active = 1;
            mem_cnt = lat;
            bus.MEM_BUSYWAIT = 1'b1;
        end else if (mem_cnt > 0) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                bus.MEM_BUSYWAIT = 1'b0;
                bus.MEM_READDATA = mem_block(bus.MEM_ADDRESS);
            end
        end
    end

    // Reference model: which block each line holds, and the miss total.
    bit          mv [8];
    logic [24:0] mt [8];
    int          mc = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mv[i] = 0;
        mc = 0;
    endtask

    // Monitor: every delivered instruction is checked against the queue.
    always @(negedge CLOCK) begin
        if (RESET && bus.READ && !bus.BUSYWAIT) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", exp_q.size(), 1);
            end else begin
                mon_e = exp_q.pop_front();
                check("addr", bus.ADDRESS, mon_e.addr);
                check("inst", bus.INSTRUCTION, mon_e.inst);
                check("miss_count", bus.MISS_COUNT, mon_e.cnt);
            end
        end
    end

    // One fetch; 'alt' != 'a' drives a different PC for part of the stall.
    task automatic request(input logic [31:0] a, input logic [31:0] alt);
        logic [2:0]  ix;
        logic [24:0] tg;
        bit miss;
        int stall;
        int my_lat;
        ix = a[6:4];
        tg = a[31:7];
        my_lat = lat;
        miss = !(mv[ix] && mt[ix] == tg);
        if (miss) begin
            mv[ix] = 1;
            mt[ix] = tg;
            if (mc < 65535) mc++;
        end
        exp_q.push_back('{addr: a, inst: mem_word(a[31:4], a[3:2]), cnt: 16'(mc)});
        bus.READ = 1'b1;
        bus.ADDRESS = a;
        @(negedge CLOCK);
        check("busy_at_once", bus.BUSYWAIT, miss);
        if (miss) begin
            stall = 1;
            while (bus.BUSYWAIT && stall < 200) begin
                @(negedge CLOCK);
                if (stall == 1) begin
                    check("mem_read", bus.MEM_READ, 1);
                    check("mem_address", bus.MEM_ADDRESS, a[31:4]);
                end
                if (alt != a && stall == 2) #1 bus.ADDRESS = alt;
                if (alt != a && stall == 3) begin
                    check("mem_address_held", bus.MEM_ADDRESS, a[31:4]);
                    #1 bus.ADDRESS = a;
                end
                if (bus.BUSYWAIT) stall++;
            end
            check("stall_cycles", stall, my_lat + 3);
        end else begin
            check("no_mem_read", bus.MEM_READ, 0);
        end
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        bus.READ = 1'b0;
        bus.ADDRESS = '0;
        model_reset();

        // Reset state, with a fetch request held during reset.
        repeat (2) @(posedge CLOCK);
        #1 bus.READ = 1'b1;
        @(negedge CLOCK);
        check("rst_busywait", bus.BUSYWAIT, 0);
        check("rst_mem_read", bus.MEM_READ, 0);
        check("rst_mem_address", bus.MEM_ADDRESS, 0);
        check("rst_miss_count", bus.MISS_COUNT, 0);
        check("rst_instruction", bus.INSTRUCTION, 0);
        bus.READ = 1'b0;
        @(posedge CLOCK);
        #1 RESET = 1'b1;

        // Cold miss then hits within block 0.
        lat = 5;
        request(32'h0, 32'h0);
        request(32'h4, 32'h4);
        request(32'h8, 32'h8);
        request(32'hC, 32'hC);

        // Conflict on line 0, then the original block misses again.
        request(32'h80, 32'h80);
        request(32'h0, 32'h0);

        // PC wanders during the stall; fill must use the latched address.
        request(32'h10, 32'h40);
        request(32'h14, 32'h14);

        // READ low: no stall, no memory traffic, no state change.
        bus.READ = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.ADDRESS = $urandom;
            @(negedge CLOCK);
            check("idle_busywait", bus.BUSYWAIT, 0);
            check("idle_mem_read", bus.MEM_READ, 0);
            check("idle_miss_count", bus.MISS_COUNT, mc);
            @(posedge CLOCK);
            #1;
        end
        request(32'h18, 32'h18);

        // Reset in the middle of a fill.
        bus.READ = 1'b1;
        bus.ADDRESS = 32'h200;
        repeat (3) @(negedge CLOCK);
        check("pre_reset_mem_read", bus.MEM_READ, 1);
        #2 RESET = 1'b0;
        #1;
        check("midrst_mem_read", bus.MEM_READ, 0);
        check("midrst_busywait", bus.BUSYWAIT, 0);
        model_reset();
        bus.READ = 1'b0;
        @(posedge CLOCK);
        @(posedge CLOCK);
        #1 RESET = 1'b1;
        request(32'h0, 32'h0);

        // Randomized traffic over a small set of conflicting tags.
        for (int n = 0; n < 200; n++) begin
            lat = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
                bus.READ = 1'b0;
                @(posedge CLOCK);
                #1;
            end
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 4) | $urandom_range(0, 15);
            request(a, a);
        end

        bus.READ = 1'b0;
        repeat (3) @(negedge CLOCK);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ins_cache.md
Name: ins_cache

Overview:
- Direct-mapped instruction cache between the IF stage (PC) and the 128-bit-block instruction memory.
- Returns the 32-bit instruction for the PC on a hit with zero added cycles.
- On a miss, stalls the pipeline via BUSYWAIT, fetches the 16-byte block from instruction memory with a READ/BUSYWAIT handshake, fills the line, then serves the hit.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two; index width IDX = log2(NUM_BLOCKS).
- TAG_W, 25, tag width; equals 28 - IDX.

Ports:
- CLOCK  in  1  system clock; all state updates on the posedge.
- RESET  in  1  asynchronous, active-low reset.
- READ  in  1  CPU fetch request.
- ADDRESS  in  32  PC (byte address).
- INSTRUCTION  out  32  fetched instruction.
- BUSYWAIT  out  1  stall to CPU.
- MEM_READ  out  1  read request to instruction memory.
- MEM_ADDRESS  out  28  block address to memory.
- MEM_READDATA  in  128  block from memory.
- MEM_BUSYWAIT  in  1  memory busy.
- MISS_COUNT  out  16  saturating miss counter.

Behaviour:
- Address split:
  - ADDRESS[1:0] ignored.
  - ADDRESS[3:2] selects the word.
  - ADDRESS[3+IDX:4] is the index.
  - ADDRESS[31:4+IDX] is the tag.
  - Block address = ADDRESS[31:4].
- Storage per line: valid bit, TAG_W tag, 128-bit data.
  - Word w occupies data[32w+31:32w]; byte 0 of the block is in [7:0].
- HIT = READ & valid[idx] & (tag[idx] == ADDRESS tag). Computed combinationally, with no clock edge needed.
- Reset:
  - RESET low, asynchronous: all valid bits cleared, state=IDLE, MEM_READ=0, MEM_ADDRESS=0, MISS_COUNT=0.
  - While RESET is low: BUSYWAIT=0 and INSTRUCTION=0.
  - Tag and data arrays are not cleared.
- Outputs in IDLE:
  - INSTRUCTION = selected word when HIT, else holds its last value (latched on a hit).
  - BUSYWAIT = READ & ~HIT. It rises in the same cycle the miss is presented.
  - READ=0 gives BUSYWAIT=0 and no state change.
- FSM states: IDLE, MEM_FETCH, UPDATE.
  - IDLE: on a posedge with READ & ~HIT, latch block address (ADDRESS[31:4]) and index into miss registers, increment MISS_COUNT (saturate at 16'hFFFF), go to MEM_FETCH.
  - MEM_FETCH: MEM_READ=1, MEM_ADDRESS = latched block address, BUSYWAIT=1. Stay while MEM_BUSYWAIT=1. At the first posedge sampling MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE. MEM_BUSYWAIT is already 1 at the first edge after MEM_READ rises.
  - UPDATE: MEM_READ=0, BUSYWAIT=1. At the posedge, write captured data, latched tag and valid=1 into the latched index, then go to IDLE.
  - Back in IDLE, the same PC now hits, so BUSYWAIT falls combinationally in that cycle.
- Miss latency: IDLE detect, then MEM_FETCH for memory latency + 1 cycle, then UPDATE 1 cycle, then hit. Minimum 3 cycles of stall beyond the memory busy period.
- ADDRESS must be held stable by the CPU while BUSYWAIT=1. The fill uses the latched address regardless, so a changed ADDRESS during the miss cannot corrupt the fill.
- READ dropping during MEM_FETCH: the fill still completes (the line is written); BUSYWAIT follows the FSM until return to IDLE.
- Conflict miss (valid line, tag mismatch): the line is overwritten. No write-back is needed because the cache is read-only.
- RESET asserted mid-miss: immediate IDLE, MEM_READ=0, no line written, valid bits cleared. A memory response arriving later is ignored.
- MISS_COUNT increments once per miss (on the IDLE→MEM_FETCH edge) and never wraps.

Test Plan:
- Reset/cold miss:
  - Stimulus: RESET low then high; READ=1, ADDRESS=32'h0000_0000; memory preloaded with block 0 = 128'h00000013_00100093_00200113_00300193, latency 5 cycles.
  - Required: BUSYWAIT=1 at once; MEM_READ=1 with MEM_ADDRESS=28'h0 the next cycle; after fill, INSTRUCTION=32'h0030_0193 and BUSYWAIT=0; MISS_COUNT=1.
- Hits within the block:
  - Stimulus: ADDRESS=0x4, 0x8, 0xC on consecutive cycles.
  - Required: BUSYWAIT=0 every cycle; INSTRUCTION = 32'h0020_0113, 32'h0010_0093, 32'h0000_0013; MEM_READ stays 0; MISS_COUNT stays 1.
- Conflict miss (NUM_BLOCKS=8):
  - Stimulus: ADDRESS=32'h0000_0080 (same index 0, tag 1).
  - Required: miss; MEM_ADDRESS=28'h000_0008; line replaced.
  - Then ADDRESS=0x0: misses again; MISS_COUNT=3.
- Address change during stall:
  - Stimulus: miss on 0x10; ADDRESS driven to 0x40 mid-MEM_FETCH.
  - Required: MEM_ADDRESS stays 28'h1; line 1 is filled with tag of 0x10.
- Reset mid-miss:
  - Stimulus: RESET pulled low during MEM_FETCH.
  - Required: MEM_READ=0 and BUSYWAIT=0 asynchronously; after release, ADDRESS=0x0 misses (valid bits cleared); MISS_COUNT restarts at 1.
- READ=0 idle:
  - Stimulus: READ=0 with any ADDRESS.
  - Required: BUSYWAIT=0; no MEM_READ; no state change.
